// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the execution sequencer: state encoding, fault codes,
// the RD opcode and a helper that clamps wait-state parameters to the counter range.
package exec_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [1:0] FLT_NONE = 2'b00;
  localparam logic [1:0] FLT_OVF  = 2'b01;
  localparam logic [1:0] FLT_UNF  = 2'b10;

  localparam logic [7:0] OPC_RD = 8'h13;

  // Wait counts live in a 3-bit counter; anything outside 1..7 is pinned to the edge.
  function automatic logic [2:0] wait_cfg(input int unsigned cycles);
    if (cycles < 1) return 3'd1;
    if (cycles > 7) return 3'd7;
    return cycles[2:0];
  endfunction

endpackage

// File: rtl/exec_sequencer_wait_counter.sv
// Loadable 3-bit down-counter used for both ROM fetch and RAM read wait states.
// 'last' flags the cycle on which the count steps to zero.
module exec_sequencer_wait_counter #(
  parameter logic [2:0] RST_VAL = 3'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       zero,
  output logic       last
);

  logic [2:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 3'd0)) begin
      count <= count - 3'd1;
    end
  end

  assign zero = (count == 3'd0);
  assign last = (count == 3'd1);

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle control FSM that turns decoder requests into one-cycle commit strobes,
// inserts ROM/RAM wait states, traps stack faults and handles halt.
// Optional single-step support: define EXEC_SEQ_SINGLE_STEP_EN.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int unsigned ROM_WAIT    = 1,
  parameter int unsigned RAM_RD_WAIT = 1,
  parameter logic [7:0]  OP_RD       = OPC_RD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instr,
  input  logic       dec_reg_w_en,
  input  logic       dec_flags_w_en,
  input  logic       dec_push_en,
  input  logic       dec_pop_en,
  input  logic       dec_ram_w_en,
  input  logic       dec_jump_en,
  input  logic       stack_full,
  input  logic       stack_empty,
  input  logic       halt_req,
`ifdef EXEC_SEQ_SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic       reg_w_en,
  output logic       flags_w_en,
  output logic       push_en,
  output logic       pop_en,
  output logic       ram_w_en,
  output logic       pc_load,
  output logic       pc_inc,
  output logic       halted,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam logic [2:0] ROM_W = wait_cfg(ROM_WAIT);
  localparam logic [2:0] RAM_W = wait_cfg(RAM_RD_WAIT);

  state_t     state, state_n;
  logic       cnt_load, cnt_dec, cnt_zero, cnt_last;
  logic [2:0] cnt_load_val;
  logic       flt_set;
  logic [1:0] flt_code_n;
  logic       stop_at_boundary;
  logic       resume;

  exec_sequencer_wait_counter #(.RST_VAL(ROM_W)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

`ifdef EXEC_SEQ_SINGLE_STEP_EN
  logic step_q;
  logic step_mode;
  logic step_rise;

  assign step_rise = step & ~step_q;

  // step_mode is re-decided on every HALT cycle, so it covers exactly one instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q    <= 1'b0;
      step_mode <= 1'b0;
    end else begin
      step_q <= step;
      if (state == ST_HALT) step_mode <= step_rise;
    end
  end

  assign stop_at_boundary = halt_req | step_mode;
  assign resume           = step_rise | ~halt_req;
`else
  assign stop_at_boundary = halt_req;
  assign resume           = ~halt_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FETCH;
      fault_code <= FLT_NONE;
    end else begin
      state <= state_n;
      if (flt_set) fault_code <= flt_code_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_load     = 1'b0;
    cnt_load_val = ROM_W;
    cnt_dec      = 1'b0;
    flt_set      = 1'b0;
    flt_code_n   = FLT_NONE;
    reg_w_en     = 1'b0;
    flags_w_en   = 1'b0;
    push_en      = 1'b0;
    pop_en       = 1'b0;
    ram_w_en     = 1'b0;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;

    case (state)
      ST_FETCH: begin
        cnt_dec = 1'b1;
        if (cnt_last || cnt_zero) state_n = ST_EXEC;
      end

      ST_EXEC: begin
        // Overflow is checked first so it wins when both stack faults coincide.
        if (dec_push_en && stack_full) begin
          flt_set    = 1'b1;
          flt_code_n = FLT_OVF;
          state_n    = ST_FAULT;
        end else if (dec_pop_en && stack_empty) begin
          flt_set    = 1'b1;
          flt_code_n = FLT_UNF;
          state_n    = ST_FAULT;
        end else if (instr == OP_RD) begin
          cnt_load     = 1'b1;
          cnt_load_val = RAM_W;
          state_n      = ST_MEM;
        end else begin
          reg_w_en   = dec_reg_w_en;
          flags_w_en = dec_flags_w_en;
          push_en    = dec_push_en;
          pop_en     = dec_pop_en;
          ram_w_en   = dec_ram_w_en;
          pc_load    = dec_jump_en;
          pc_inc     = ~dec_jump_en;
          cnt_load   = 1'b1;
          state_n    = stop_at_boundary ? ST_HALT : ST_FETCH;
        end
      end

      ST_MEM: begin
        cnt_dec = 1'b1;
        if (cnt_last || cnt_zero) begin
          reg_w_en = 1'b1;
          pc_inc   = 1'b1;
          cnt_load = 1'b1;
          state_n  = stop_at_boundary ? ST_HALT : ST_FETCH;
        end
      end

      ST_HALT: begin
        cnt_load = 1'b1;
        if (resume) state_n = ST_FETCH;
      end

      ST_FAULT: begin
        state_n = ST_FAULT;
      end

      default: begin
        state_n = ST_FETCH;
      end
    endcase
  end

  assign halted = (state == ST_HALT);
  assign fault  = (state == ST_FAULT);

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer with ROM_WAIT=1, RAM_RD_WAIT=2.
// Output vector: {reg,flags,push,pop,ramw,pc_load,pc_inc,halted,fault,code[1:0]}.
module tb_exec_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] instr;
  logic       dec_reg_w_en, dec_flags_w_en, dec_push_en, dec_pop_en;
  logic       dec_ram_w_en, dec_jump_en;
  logic       stack_full, stack_empty, halt_req;
`ifdef EXEC_SEQ_SINGLE_STEP_EN
  logic       step;
`endif
  logic       reg_w_en, flags_w_en, push_en, pop_en, ram_w_en;
  logic       pc_load, pc_inc, halted, fault;
  logic [1:0] fault_code;
  logic [10:0] obs;

  int checks;
  int failures;

  localparam logic [7:0] I_NOP = 8'h00;
  localparam logic [7:0] I_LDR = 8'h01;
  localparam logic [7:0] I_ADD = 8'h02;
  localparam logic [7:0] I_RD  = 8'h13;
  localparam logic [7:0] I_JMR = 8'h20;
  localparam logic [7:0] I_PSH = 8'h30;
  localparam logic [7:0] I_POP = 8'h31;

  exec_sequencer #(.ROM_WAIT(1), .RAM_RD_WAIT(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr          (instr),
    .dec_reg_w_en   (dec_reg_w_en),
    .dec_flags_w_en (dec_flags_w_en),
    .dec_push_en    (dec_push_en),
    .dec_pop_en     (dec_pop_en),
    .dec_ram_w_en   (dec_ram_w_en),
    .dec_jump_en    (dec_jump_en),
    .stack_full     (stack_full),
    .stack_empty    (stack_empty),
    .halt_req       (halt_req),
`ifdef EXEC_SEQ_SINGLE_STEP_EN
    .step           (step),
`endif
    .reg_w_en       (reg_w_en),
    .flags_w_en     (flags_w_en),
    .push_en        (push_en),
    .pop_en         (pop_en),
    .ram_w_en       (ram_w_en),
    .pc_load        (pc_load),
    .pc_inc         (pc_inc),
    .halted         (halted),
    .fault          (fault),
    .fault_code     (fault_code)
  );

  assign obs = {reg_w_en, flags_w_en, push_en, pop_en, ram_w_en,
                pc_load, pc_inc, halted, fault, fault_code};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    instr          = I_NOP;
    dec_reg_w_en   = 1'b0;
    dec_flags_w_en = 1'b0;
    dec_push_en    = 1'b0;
    dec_pop_en     = 1'b0;
    dec_ram_w_en   = 1'b0;
    dec_jump_en    = 1'b0;
    stack_full     = 1'b0;
    stack_empty    = 1'b0;
    halt_req       = 1'b0;
`ifdef EXEC_SEQ_SINGLE_STEP_EN
    step           = 1'b0;
`endif
  endtask

  // Leaves the bench 1 time unit after a rising edge, in the first FETCH cycle.
  task automatic test_reset();
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 11'h000) begin
      failures++;
      $display("FAIL reset_async obs=%h exp=%h", obs, 11'h000);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== 11'h000) begin
      failures++;
      $display("FAIL reset_hold obs=%h exp=%h", obs, 11'h000);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ldr_add();
    logic [10:0] exp [0:4];
    exp = '{11'h000, 11'h410, 11'h000, 11'h610, 11'h000};
    test_reset();
    for (int i = 0; i < 5; i++) begin
      instr          = (i < 2) ? I_LDR : I_ADD;
      dec_reg_w_en   = 1'b1;
      dec_flags_w_en = (i >= 2);
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin
        failures++;
        $display("FAIL ldr_add cyc%0d obs=%h exp=%h", i + 1, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rd();
    logic [10:0] exp [0:4];
    exp = '{11'h000, 11'h000, 11'h000, 11'h410, 11'h000};
    test_reset();
    for (int i = 0; i < 5; i++) begin
      instr        = I_RD;
      dec_reg_w_en = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin
        failures++;
        $display("FAIL rd_wait cyc%0d obs=%h exp=%h", i + 1, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump();
    logic [10:0] exp [0:3];
    exp = '{11'h000, 11'h020, 11'h000, 11'h010};
    test_reset();
    for (int i = 0; i < 4; i++) begin
      instr       = (i < 2) ? I_JMR : I_NOP;
      dec_jump_en = (i < 2);
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin
        failures++;
        $display("FAIL jump cyc%0d obs=%h exp=%h", i + 1, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fault();
    logic [10:0] exp [0:5];
    exp = '{11'h000, 11'h000, 11'h005, 11'h005, 11'h005, 11'h005};
    test_reset();
    for (int i = 0; i < 6; i++) begin
      instr       = I_PSH;
      dec_push_en = 1'b1;
      stack_full  = 1'b1;
      halt_req    = (i >= 2);
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin
        failures++;
        $display("FAIL overflow cyc%0d obs=%h exp=%h", i + 1, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    exp = '{11'h000, 11'h000, 11'h006, 11'h006, 11'h000, 11'h000};
    test_reset();
    for (int i = 0; i < 4; i++) begin
      instr       = I_POP;
      dec_pop_en  = 1'b1;
      stack_empty = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin
        failures++;
        $display("FAIL underflow cyc%0d obs=%h exp=%h", i + 1, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    test_reset();
    for (int i = 0; i < 3; i++) begin
      instr       = I_PSH;
      dec_push_en = 1'b1;
      dec_pop_en  = 1'b1;
      stack_full  = 1'b1;
      stack_empty = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== exp[i] && i < 2 || i == 2 && obs !== 11'h005) begin
        failures++;
        $display("FAIL both_faults cyc%0d obs=%h", i + 1, obs);
      end
      @(posedge clk); #1;
    end
    test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== ((i == 1) ? 11'h010 : 11'h000)) begin
        failures++;
        $display("FAIL fault_recover cyc%0d obs=%h exp=%h", i + 1, obs,
                 (i == 1) ? 11'h010 : 11'h000);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt_mem();
    logic [10:0] exp [0:8];
    exp = '{11'h000, 11'h000, 11'h000, 11'h410, 11'h008,
            11'h008, 11'h008, 11'h000, 11'h010};
    test_reset();
    for (int i = 0; i < 9; i++) begin
      instr        = (i < 4) ? I_RD : I_NOP;
      dec_reg_w_en = (i < 4);
      halt_req     = (i >= 2 && i <= 5);
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin
        failures++;
        $display("FAIL halt_mem cyc%0d obs=%h exp=%h", i + 1, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef EXEC_SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    logic [10:0] exp [0:8];
    exp = '{11'h000, 11'h010, 11'h008, 11'h008, 11'h000,
            11'h010, 11'h008, 11'h000, 11'h010};
    test_reset();
    for (int i = 0; i < 9; i++) begin
      halt_req = (i < 4);
      step     = (i == 3);
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin
        failures++;
        $display("FAIL single_step cyc%0d obs=%h exp=%h", i + 1, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  task automatic test_reset_mid();
    test_reset();
    instr       = I_PSH;
    dec_push_en = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 11'h000) begin
      failures++;
      $display("FAIL rst_fetch_async obs=%h exp=%h", obs, 11'h000);
    end
    @(negedge clk);
    checks++;
    if (push_en !== 1'b0) begin
      failures++;
      $display("FAIL rst_fetch_nopush push_en=%b exp=0", push_en);
    end
    @(posedge clk); #1;
    rst_n       = 1'b1;
    instr       = I_NOP;
    dec_push_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== ((i == 1) ? 11'h010 : 11'h000)) begin
        failures++;
        $display("FAIL rst_fetch_resume cyc%0d obs=%h exp=%h", i + 1, obs,
                 (i == 1) ? 11'h010 : 11'h000);
      end
      @(posedge clk); #1;
    end
    test_reset();
    instr       = I_PSH;
    dec_push_en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (obs !== 11'h110) begin
      failures++;
      $display("FAIL push_commit obs=%h exp=%h", obs, 11'h110);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 11'h000) begin
      failures++;
      $display("FAIL rst_exec_async obs=%h exp=%h", obs, 11'h000);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    clear_inputs();
    test_reset();
    test_ldr_add();
    test_rd();
    test_jump();
    test_fault();
    test_halt_mem();
`ifdef EXEC_SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
